// File: rtl/alu_serial.sv
// Digit-serial ALU (add/sub/and/or/slt) sharing one DIGIT-bit adder slice; out_valid rises WIDTH/DIGIT cycles after accept.
// in_ready only in IDLE; the result is held in DONE until out_ready, so the producer stalls while it waits.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;

  logic             is_sub_in;
  logic [WIDTH-1:0] b_in;
  logic [DIGIT:0]   sum;
  logic [DIGIT-1:0] digit;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] final_res;
  logic             slt_s;
  logic             slt_ovf;

  always_comb begin
    is_sub_in = (alu_control == OP_SUB) || (alu_control == OP_SLT);
    b_in      = is_sub_in ? ~src_b : src_b;

    sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    case (op_q)
      OP_ADD, OP_SUB, OP_SLT: digit = sum[DIGIT-1:0];
      OP_AND:                 digit = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
      OP_OR:                  digit = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
      default:                digit = '0;
    endcase
    acc_shift = (acc_q >> DIGIT) | (WIDTH'(digit) << (WIDTH - DIGIT));

    // Only meaningful on the last digit, where sum carries the true MSB of A - B.
    slt_s   = sum[DIGIT-1];
    slt_ovf = (sign_a_q == sign_b_q) && (slt_s != sign_a_q);
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR: final_res = acc_shift;
      OP_SLT:                        final_res = {{(WIDTH-1){1'b0}}, slt_s ^ slt_ovf};
      default:                       final_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = EXEC;
          cnt_d    = '0;
          a_d      = src_a;
          b_d      = b_in;
          acc_d    = '0;
          carry_d  = is_sub_in;
          op_d     = alu_control;
          sign_a_d = src_a[WIDTH-1];
          sign_b_d = b_in[WIDTH-1];
        end
      end
      EXEC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum[DIGIT];
        acc_d   = acc_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = DONE;
          result_d = final_res;
          zero_d   = (final_res == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
